// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit word per line.
// Latency: hits return one cycle after the lookup; misses return one cycle after the matching memory done pulse.
// Backpressure: none on IF; a miss holds mem_inst_req_o until a matching done pulse or a flush.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   if_req_i/if_addr_i/flush_i   lookup request from IF, redirect cancels lookup or miss
//   if_valid_o/if_inst_o/if_addr_o  one-cycle return pulse with word and its address
//   mem_inst_req_o/mem_inst_addr_o  single-word fetch request to the memory controller
//   mem_inst_i/mem_inst_addr_i/mem_inst_done_i  memory return (word, address, pulse)
module icache #(
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_addr_o,
  output logic        mem_inst_req_o,
  output logic [31:0] mem_inst_addr_o,
  input  logic [31:0] mem_inst_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_inst_done_i
);

  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t             r_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES];
  logic [31:0]        r_miss_addr;
  logic               r_if_valid;
  logic [31:0]        r_if_inst;
  logic [31:0]        r_if_addr;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_miss_idx;
  logic [TAG_W-1:0]   w_miss_tag;
  logic               w_hit;
  logic               w_done_match;
  logic               w_fill;

  assign w_idx        = if_addr_i[INDEX_W+1:2];
  assign w_tag        = if_addr_i[31:INDEX_W+2];
  assign w_miss_idx   = r_miss_addr[INDEX_W+1:2];
  assign w_miss_tag   = r_miss_addr[31:INDEX_W+2];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_done_match = mem_inst_done_i && (mem_inst_addr_i == r_miss_addr);
  // Flush takes priority over a same-cycle matching return.
  assign w_fill       = (r_state == S_MISS) && !flush_i && w_done_match;

  // Request drops in the done cycle so the controller never sees a second fetch.
  assign mem_inst_req_o  = (r_state == S_MISS) && !flush_i && !w_done_match;
  assign mem_inst_addr_o = r_miss_addr;
  assign if_valid_o      = r_if_valid;
  assign if_inst_o       = r_if_inst;
  assign if_addr_o       = r_if_addr;

  // Tag/data arrays carry no reset; the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (rst && w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= mem_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_miss_addr <= 32'h0;
      r_if_valid  <= 1'b0;
      r_if_inst   <= 32'h0;
      r_if_addr   <= 32'h0;
    end else begin
      r_if_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!flush_i && if_req_i) begin
            if (w_hit) begin
              r_if_valid <= 1'b1;
              r_if_inst  <= r_data[w_idx];
              r_if_addr  <= if_addr_i;
            end else begin
              r_miss_addr <= if_addr_i;
              r_state     <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else if (w_done_match) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_if_valid          <= 1'b1;
            r_if_inst           <= mem_inst_i;
            r_if_addr           <= r_miss_addr;
            r_state             <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        flush_i;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_addr_o;
  logic        mem_inst_req_o;
  logic [31:0] mem_inst_addr_o;
  logic [31:0] mem_inst_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_inst_done_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the cache should hold, keyed by line number.
  bit          m_valid [128];
  logic [31:0] m_addr  [128];
  logic [31:0] m_data  [128];

  icache dut (
    .clk             (clk),
    .rst             (rst),
    .if_req_i        (if_req_i),
    .if_addr_i       (if_addr_i),
    .flush_i         (flush_i),
    .if_valid_o      (if_valid_o),
    .if_inst_o       (if_inst_o),
    .if_addr_o       (if_addr_o),
    .mem_inst_req_o  (mem_inst_req_o),
    .mem_inst_addr_o (mem_inst_addr_o),
    .mem_inst_i      (mem_inst_i),
    .mem_inst_addr_i (mem_inst_addr_i),
    .mem_inst_done_i (mem_inst_done_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 128);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_addr[line_of(a)] == a);
  endfunction

  task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
    m_valid[line_of(a)] = 1'b1;
    m_addr[line_of(a)]  = a;
    m_data[line_of(a)]  = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endtask

  // Drive one miss to completion with fixed timing (stimulus only).
  task automatic fill(input logic [31:0] a, input logic [31:0] d, input int lat);
    if_req_i = 1'b1; if_addr_i = a;
    @(negedge clk);
    if_req_i = 1'b0;
    repeat (lat) @(negedge clk);
    mem_inst_done_i = 1'b1; mem_inst_i = d; mem_inst_addr_i = a;
    @(negedge clk);
    mem_inst_done_i = 1'b0;
    @(negedge clk);
    model_fill(a, d);
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0; flush_i = 1'b0;
    mem_inst_done_i = 1'b0; mem_inst_i = 32'h0; mem_inst_addr_i = 32'h0;
    model_clear();
    repeat (2) @(negedge clk);
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_valid_o); end
    n_cmp++; if (if_inst_o !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", if_inst_o); end
    n_cmp++; if (if_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", if_addr_o); end
    n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL rst_memreq: got %b want 0", mem_inst_req_o); end
    n_cmp++; if (mem_inst_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_memaddr: got %h want 0", mem_inst_addr_o); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL post_rst_miss_req: got %b want 1", mem_inst_req_o); end
    n_cmp++; if (mem_inst_addr_o !== 32'h0) begin n_err++; $display("FAIL post_rst_miss_addr: got %h want 0", mem_inst_addr_o); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b want 0", if_valid_o); end
    flush_i = 1'b1; if_req_i = 1'b0;
    #1;
    n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL post_rst_flush_req: got %b want 0", mem_inst_req_o); end
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic test_cold_miss();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    @(negedge clk);
    if_req_i = 1'b0;
    n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL cold_req: got %b want 1", mem_inst_req_o); end
    n_cmp++; if (mem_inst_addr_o !== 32'h100) begin n_err++; $display("FAIL cold_memaddr: got %h want 100", mem_inst_addr_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL cold_req_hold: got %b want 1 (cycle %0d)", mem_inst_req_o, i); end
    end
    mem_inst_done_i = 1'b1; mem_inst_i = 32'h00A00093; mem_inst_addr_i = 32'h100;
    #1;
    n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL cold_req_done: got %b want 0", mem_inst_req_o); end
    @(negedge clk);
    mem_inst_done_i = 1'b0;
    n_cmp++; if (if_valid_o !== 1'b1) begin n_err++; $display("FAIL cold_valid: got %b want 1", if_valid_o); end
    n_cmp++; if (if_inst_o !== 32'h00A00093) begin n_err++; $display("FAIL cold_inst: got %h want 00a00093", if_inst_o); end
    n_cmp++; if (if_addr_o !== 32'h100) begin n_err++; $display("FAIL cold_addr: got %h want 100", if_addr_o); end
    @(negedge clk);
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL cold_pulse: got %b want 0", if_valid_o); end
    model_fill(32'h100, 32'h00A00093);
  endtask

  task automatic test_hit_stream();
    fill(32'h104, mem_word(32'h104), 2);
    if_req_i = 1'b1; if_addr_i = 32'h100;
    @(negedge clk);
    if_addr_i = 32'h104;
    n_cmp++; if (if_valid_o !== 1'b1) begin n_err++; $display("FAIL hit0_valid: got %b want 1", if_valid_o); end
    n_cmp++; if (if_inst_o !== m_data[line_of(32'h100)]) begin n_err++; $display("FAIL hit0_inst: got %h want %h", if_inst_o, m_data[line_of(32'h100)]); end
    n_cmp++; if (if_addr_o !== 32'h100) begin n_err++; $display("FAIL hit0_addr: got %h want 100", if_addr_o); end
    n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL hit0_memreq: got %b want 0", mem_inst_req_o); end
    @(negedge clk);
    if_req_i = 1'b0;
    n_cmp++; if (if_valid_o !== 1'b1) begin n_err++; $display("FAIL hit1_valid: got %b want 1", if_valid_o); end
    n_cmp++; if (if_inst_o !== mem_word(32'h104)) begin n_err++; $display("FAIL hit1_inst: got %h want %h", if_inst_o, mem_word(32'h104)); end
    n_cmp++; if (if_addr_o !== 32'h104) begin n_err++; $display("FAIL hit1_addr: got %h want 104", if_addr_o); end
    n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL hit1_memreq: got %b want 0", mem_inst_req_o); end
    @(negedge clk);
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL hit_end_valid: got %b want 0", if_valid_o); end
  endtask

  task automatic test_conflict();
    if_req_i = 1'b1; if_addr_i = 32'h300;
    @(negedge clk);
    if_req_i = 1'b0;
    n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL conf_miss_req: got %b want 1", mem_inst_req_o); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL conf_miss_valid: got %b want 0", if_valid_o); end
    mem_inst_done_i = 1'b1; mem_inst_i = mem_word(32'h300); mem_inst_addr_i = 32'h300;
    @(negedge clk);
    mem_inst_done_i = 1'b0;
    n_cmp++; if (if_inst_o !== mem_word(32'h300)) begin n_err++; $display("FAIL conf_inst: got %h want %h", if_inst_o, mem_word(32'h300)); end
    model_fill(32'h300, mem_word(32'h300));
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h100;
    @(negedge clk);
    if_req_i = 1'b0;
    n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL conf_evict_req: got %b want 1", mem_inst_req_o); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL conf_evict_valid: got %b want 0", if_valid_o); end
    mem_inst_done_i = 1'b1; mem_inst_i = 32'h00A00093; mem_inst_addr_i = 32'h100;
    @(negedge clk);
    mem_inst_done_i = 1'b0;
    model_fill(32'h100, 32'h00A00093);
    @(negedge clk);
  endtask

  task automatic test_flush_miss();
    if_req_i = 1'b1; if_addr_i = 32'h200;
    @(negedge clk);
    if_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL flush_req: got %b want 0", mem_inst_req_o); end
    @(negedge clk);
    flush_i = 1'b0;
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", if_valid_o); end
    n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL flush_idle_req: got %b want 0", mem_inst_req_o); end
    mem_inst_done_i = 1'b1; mem_inst_i = 32'hDEADBEEF; mem_inst_addr_i = 32'h200;
    @(negedge clk);
    mem_inst_done_i = 1'b0;
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL late_done_valid: got %b want 0", if_valid_o); end
    if_req_i = 1'b1; if_addr_i = 32'h200;
    @(negedge clk);
    if_req_i = 1'b0;
    n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL flush_rereq_miss: got %b want 1", mem_inst_req_o); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_rereq_valid: got %b want 0", if_valid_o); end
    mem_inst_done_i = 1'b1; mem_inst_i = mem_word(32'h200); mem_inst_addr_i = 32'h200;
    @(negedge clk);
    mem_inst_done_i = 1'b0;
    n_cmp++; if (if_inst_o !== mem_word(32'h200)) begin n_err++; $display("FAIL flush_refill_inst: got %h want %h", if_inst_o, mem_word(32'h200)); end
    model_fill(32'h200, mem_word(32'h200));
    @(negedge clk);
  endtask

  task automatic test_stale_reset();
    if_req_i = 1'b1; if_addr_i = 32'h400;
    @(negedge clk);
    if_req_i = 1'b0;
    mem_inst_done_i = 1'b1; mem_inst_i = 32'h12345678; mem_inst_addr_i = 32'h3FC;
    #1;
    n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL stale_req: got %b want 1", mem_inst_req_o); end
    @(negedge clk);
    mem_inst_done_i = 1'b0;
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL stale_valid: got %b want 0", if_valid_o); end
    n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL stale_req_hold: got %b want 1", mem_inst_req_o); end
    rst = 1'b0;
    mem_inst_done_i = 1'b1; mem_inst_i = 32'h0BADF00D; mem_inst_addr_i = 32'h400;
    @(negedge clk);
    mem_inst_done_i = 1'b0;
    rst = 1'b1;
    model_clear();
    n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL rstmiss_req: got %b want 0", mem_inst_req_o); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmiss_valid: got %b want 0", if_valid_o); end
    @(negedge clk);
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmiss_valid2: got %b want 0", if_valid_o); end
    for (int k = 0; k < 2; k++) begin
      if_req_i = 1'b1; if_addr_i = (k == 0) ? 32'h100 : 32'h400;
      @(negedge clk);
      if_req_i = 1'b0;
      n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL rstmiss_invalid_req: got %b want 1 addr %h", mem_inst_req_o, if_addr_i); end
      n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmiss_invalid_valid: got %b want 0 addr %h", if_valid_o, if_addr_i); end
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
    end
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] a;
    int lat;
    for (int t = 0; t < 120; t++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2);
      if_req_i = 1'b1; if_addr_i = a;
      @(negedge clk);
      if_req_i = 1'b0;
      if (model_hit(a)) begin
        n_cmp++; if (if_valid_o !== 1'b1 || if_inst_o !== m_data[line_of(a)] || if_addr_o !== a || mem_inst_req_o !== 1'b0) begin
          n_err++; $display("FAIL rnd_hit: got v%b %h @%h req%b want v1 %h @%h req0", if_valid_o, if_inst_o, if_addr_o, mem_inst_req_o, m_data[line_of(a)], a);
        end
      end else begin
        n_cmp++; if (mem_inst_req_o !== 1'b1 || mem_inst_addr_o !== a || if_valid_o !== 1'b0) begin
          n_err++; $display("FAIL rnd_miss: got req%b @%h v%b want req1 @%h v0", mem_inst_req_o, mem_inst_addr_o, if_valid_o, a);
        end
        lat = $urandom_range(0, 4);
        for (int c = 0; c < lat; c++) begin
          if ($urandom_range(0, 3) == 0) begin
            mem_inst_done_i = 1'b1; mem_inst_i = 32'hFFFFFFFF; mem_inst_addr_i = a ^ 32'h4;
          end
          #1;
          n_cmp++; if (mem_inst_req_o !== 1'b1) begin n_err++; $display("FAIL rnd_wait_req: got %b want 1 @%h", mem_inst_req_o, a); end
          @(negedge clk);
          mem_inst_done_i = 1'b0;
        end
        if ($urandom_range(0, 4) == 0) begin
          flush_i = 1'b1;
          #1;
          n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL rnd_flush_req: got %b want 0", mem_inst_req_o); end
          @(negedge clk);
          flush_i = 1'b0;
          n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL rnd_flush_valid: got %b want 0", if_valid_o); end
        end else begin
          mem_inst_done_i = 1'b1; mem_inst_i = mem_word(a); mem_inst_addr_i = a;
          #1;
          n_cmp++; if (mem_inst_req_o !== 1'b0) begin n_err++; $display("FAIL rnd_done_req: got %b want 0", mem_inst_req_o); end
          @(negedge clk);
          mem_inst_done_i = 1'b0;
          n_cmp++; if (if_valid_o !== 1'b1 || if_inst_o !== mem_word(a) || if_addr_o !== a) begin
            n_err++; $display("FAIL rnd_fill: got v%b %h @%h want v1 %h @%h", if_valid_o, if_inst_o, if_addr_o, mem_word(a), a);
          end
          model_fill(a, mem_word(a));
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL rnd_end_valid: got %b want 0", if_valid_o); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_flush_miss();
    test_stale_reset();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
